apb_req_master: RTL and testbench

Single-outstanding APB requester that sits directly upstream of the APB slave memory. Accepts read/write commands on a valid/ready request channel, drives the APB SETUP and ACCESS phases, and waits through any number of slave wait states. Returns read data and error status on a valid/ready response channel. A wait-state timeout guarantees the bus never hangs.

---
 rtl/apb_req_master.sv | 148 ++++++++++++++
 tb/tb_apb_req_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
//
// Single-outstanding APB requester. A command taken on the valid/ready
// request channel is driven onto APB as a SETUP phase followed by an ACCESS
// phase. The ACCESS phase waits on PREADY for any number of wait states.
// The result comes back on a valid/ready response channel. A wait-state
// timeout aborts a transfer whose slave never answers, so the bus cannot
// hang.
//
// Ports
//   PCLK, PRESET          clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready   request handshake; req_write, req_addr, req_wdata,
//                         req_strb carry the command
//   rsp_valid/rsp_ready   response handshake; rsp_rdata, rsp_err,
//                         rsp_timeout carry the result
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB   APB requester outputs
//   PRDATA, PREADY, PSLVERR                       APB completer inputs
// ---------------------------------------------------------------------------
module apb_req_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Wait counter holds at its maximum instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

  // Last permitted wait cycle; a zero TIMEOUT_CYCLES disables the abort.
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      case (state)
        // IDLE: capture the command straight into the APB output registers.
        ST_IDLE: begin
          if (req_valid) begin
            PWRITE    <= req_write;
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            PSTRB     <= req_write ? req_strb : '0;
            PSEL      <= 1'b1;
            req_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end

        // SETUP: one cycle, then enable.
        ST_SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end

        // ACCESS: PREADY completion outranks the timeout in the same cycle.
        ST_ACCESS: begin
          if (PREADY) begin
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end

        // RESP: hold the response until it is taken.
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// ---------------------------------------------------------------------------
// tb_apb_req_master
//
// Directed bench for apb_req_master with a small APB memory completer whose
// PREADY timing is chosen per transfer. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_apb_req_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_req_master dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  // Completer: PREADY rises in ACCESS cycle number ready_cycle (0 = never).
  // Address 0xC4 answers with PSLVERR.
  logic [31:0] mem [256];
  int          ready_cycle = 1;
  int          acc_cnt = 0;

  assign PREADY  = PSEL && PENABLE && (ready_cycle != 0) && (acc_cnt == ready_cycle - 1);
  assign PSLVERR = PREADY && (PADDR == 8'hC4);
  assign PRDATA  = mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR][b*8 +: 8] <= PWDATA[b*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and let it be accepted; returns at the negedge in SETUP.
  task automatic send_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int rc);
    ready_cycle = rc;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = st;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    check("setup_psel",    PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_req_rdy", req_ready, 0);
    check("setup_paddr",   PADDR, addr);
    check("setup_pwrite",  PWRITE, wr);
    check("setup_pstrb",   PSTRB, wr ? st : 4'h0);
  endtask

  // Counts edges after acceptance until rsp_valid, and ACCESS cycles seen.
  task automatic wait_rsp(output int n_edges, output int n_acc);
    n_edges = 0;
    n_acc   = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      if (PSEL && PENABLE) n_acc++;
      @(posedge PCLK);
      n_edges++;
      @(negedge PCLK);
    end
    check("rsp_arrived", rsp_valid, 1);
    check("rsp_psel_low", PSEL, 0);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_cleared", rsp_valid, 0);
    check("idle_req_rdy", req_ready, 1);
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input int rc,
                      input int exp_edges, input int exp_acc, input logic [31:0] exp_rd,
                      input logic exp_err, input logic exp_to);
    int ne, na;
    send_req(wr, addr, wd, st, rc);
    wait_rsp(ne, na);
    check({tag, "_edges"},   ne, exp_edges);
    check({tag, "_access"},  na, exp_acc);
    check({tag, "_rdata"},   rsp_rdata, exp_rd);
    check({tag, "_err"},     rsp_err, exp_err);
    check({tag, "_timeout"}, rsp_timeout, exp_to);
    take_rsp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, na, idle_cnt, rv_cnt, stray;
    logic [31:0] held;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'hC4] = 32'hDEAD_BEEF;

    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_req_ready", req_ready, 1);
    check("rst_psel",      PSEL, 0);
    check("rst_penable",   PENABLE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_rsp_to",    rsp_timeout, 0);
    check("rst_paddr",     PADDR, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;

    // Full write and read-back through the 6th-cycle PREADY slave
    xfer("wr4", 1'b1, 8'h10, 32'hA5A5_5A5A, 4'hF, 6, 7, 6, 32'h0, 1'b0, 1'b0);
    xfer("rd4", 1'b0, 8'h10, 32'h1234_5678, 4'hF, 6, 7, 6, 32'hA5A5_5A5A, 1'b0, 1'b0);

    // Partial strobe over the earlier word, zero-wait slave
    xfer("wrp", 1'b1, 8'h10, 32'hFFFF_FFFF, 4'h3, 1, 2, 1, 32'h0, 1'b0, 1'b0);
    xfer("rdp", 1'b0, 8'h10, 32'h0, 4'h0, 1, 2, 1, 32'hA5A5_FFFF, 1'b0, 1'b0);

    // Slave error: read data suppressed
    xfer("serr", 1'b0, 8'hC4, 32'h0, 4'h0, 1, 2, 1, 32'h0, 1'b1, 1'b0);

    // Timeout with a silent slave, then PREADY on the very last cycle
    xfer("tmo",  1'b0, 8'h10, 32'h0, 4'h0, 0, 17, 16, 32'h0, 1'b1, 1'b1);
    xfer("last", 1'b0, 8'h10, 32'h0, 4'h0, 16, 17, 16, 32'hA5A5_FFFF, 1'b0, 1'b0);

    // Backpressure: response held, a new request is not taken
    send_req(1'b0, 8'h10, 32'h0, 4'h0, 2);
    wait_rsp(ne, na);
    check("bp_edges", ne, 3);
    held = rsp_rdata;
    check("bp_rdata", held, 32'hA5A5_FFFF);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 32'h5555_AAAA; req_strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("bp_valid",   rsp_valid, 1);
      check("bp_hold",    rsp_rdata, 32'hA5A5_FFFF);
      check("bp_req_rdy", req_ready, 0);
      check("bp_psel",    PSEL, 0);
    end
    req_valid = 1'b0;
    take_rsp();
    check("bp_no_setup", PSEL, 0);
    check("bp_mem40",    mem[8'h40], 32'h0);

    // Reset in the middle of ACCESS discards the transfer
    send_req(1'b0, 8'h10, 32'h0, 4'h0, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_access", PENABLE, 1);
    PRESET = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    check("mid_psel",    PSEL, 0);
    check("mid_penable", PENABLE, 0);
    check("mid_rsp",     rsp_valid, 0);
    check("mid_req_rdy", req_ready, 1);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) stray++;
    end
    check("mid_no_rsp", stray, 0);
    xfer("after", 1'b0, 8'h10, 32'h0, 4'h0, 1, 2, 1, 32'hA5A5_FFFF, 1'b0, 1'b0);

    // Back-to-back with rsp_ready held: one transfer every 4 cycles
    ready_cycle = 1;
    @(negedge PCLK);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_strb = 4'h0;
    idle_cnt = 0;
    rv_cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) idle_cnt++;
      if (rsp_valid) rv_cnt++;
      @(negedge PCLK);
    end
    req_valid = 1'b0;
    check("b2b_idle", idle_cnt, 3);
    check("b2b_rsp",  rv_cnt, 3);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("b2b_end_idle", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
